wb_grf: RTL and testbench
=========================

# wb_grf

Write-back stage general register file for the five-stage MIPS pipeline. Consumes the MEM/WB pipeline-register outputs, selects the write-back value, commits it to a 32×32-bit register file, and serves the two decode-stage read ports with same-cycle write-through bypass. Also keeps a retired-write counter and a registered commit trace for the testbench and grader.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, value reported on `trace_pc` while no commit has occurred.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserting it (0) clears all state immediately, independent of `clk`.
- `wb_pc`  in  32  PC of the instruction in WB.
- `wb_regaddr`  in  5  destination register number.
- `wb_alures`  in  32  ALU result.
- `wb_memres`  in  32  load data.
- `wb_memToReg`  in  1  select load data.
- `wb_regWrite`  in  1  instruction writes the register file.
- `wb_jump`  in  1  link instruction (jal/jalr); write data is `wb_pc + 8`.
- `rs_addr`  in  5  read port 1 address (D stage).
- `rt_addr`  in  5  read port 2 address (D stage).
- `rs_data`  out  32  read port 1 data.
- `rt_data`  out  32  read port 2 data.
- `wb_data`  out  32  selected write-back value (combinational, for M/E forwarding).
- `commit_count`  out  32  number of committed writes since reset.
- `trace_valid`  out  1  a write committed on the previous edge.
- `trace_pc`  out  32  PC of that write.
- `trace_addr`  out  5  register written.
- `trace_data`  out  32  value written.

## Operation
- Write-data select, priority order: `wb_jump` → `wb_pc + 8` (modulo 2^32); else `wb_memToReg` → `wb_memres`; else `wb_alures`. Drives `wb_data` regardless of `wb_regWrite`.
- Commit condition: `wb_regWrite == 1` and `wb_regaddr != 0`. On the rising edge with commit: `gpr[wb_regaddr] <= wb_data`, `commit_count` increments by 1 (wraps 32'hFFFF_FFFF → 0), trace registers load {1, `wb_pc`, `wb_regaddr`, `wb_data`}.
- Edge without commit (including write to $0): register file and counter unchanged; `trace_valid <= 0`; `trace_pc/addr/data` hold previous values.
- Register $0 reads 0 always; never stored.
- Read ports combinational. Bypass: if commit condition holds this cycle and `rs_addr == wb_regaddr`, `rs_data = wb_data`; otherwise `gpr[rs_addr]`. Same rule for `rt_*`. Address 0 returns 0 even if `wb_regaddr == 0` and `wb_regWrite == 1`.
- Both read ports may address the same register; both bypass identically.

## Timing
- Reset (`reset == 0`, asynchronous): all 31 registers 0, `commit_count` 0, `trace_valid` 0, `trace_pc` RESET_PC, `trace_addr` 0, `trace_data` 0. Read ports then return 0. Holds while low; first commit possible on first rising edge after `reset` returns 1.
- Reset asserted mid-cycle during a pending commit: the commit is lost; state is reset values.
- Write latency: value visible on read ports in the same cycle via bypass, from storage after the edge.
- Trace latency: one cycle after the commit edge, valid for exactly one cycle per commit; back-to-back commits give consecutive `trace_valid` pulses.
- No handshake; WB always accepted every cycle.

## Test plan
- Reset: drive `reset=0` between edges → all outputs at reset values immediately; read `rs_addr=5` → 0; `trace_pc = 32'h3000`.
- ALU write + bypass: `wb_regWrite=1, wb_regaddr=8, wb_alures=32'h1234_5678, rs_addr=8` → `rs_data=32'h1234_5678` before edge; after edge `trace_valid=1, trace_addr=8, commit_count=1`; next cycle with `wb_regWrite=0` → `rs_data` still 32'h1234_5678, `trace_valid=0`.
- Load vs jump priority: `wb_memToReg=1, wb_jump=1, wb_pc=32'h3010, wb_regaddr=31` → `wb_data=32'h3018`, `$31=32'h3018`; with `wb_jump=0, wb_memres=32'hDEAD_BEEF` → `$31=32'hDEAD_BEEF`.
- $0 protection: `wb_regWrite=1, wb_regaddr=0, wb_alures=32'hFFFF_FFFF, rs_addr=0, rt_addr=0` → both reads 0, `commit_count` unchanged, `trace_valid=0`.
- Back-to-back and dual read: commits to $1=1, $2=2, $1=3 on three edges → three consecutive `trace_valid` pulses, `commit_count=3`; `rs_addr=rt_addr=1` → both 3.
- Counter wrap: after 2^32−1 commits (or forced via long run at reduced check), one more commit → `commit_count=0`.

Source files
------------

// File: rtl/wb_grf.sv
// Write-back stage register file: selects the WB value, commits it to 32x32 storage,
// serves two bypassed D-stage read ports, and keeps a commit counter plus commit trace.

module wb_grf_rdport #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic [AW-1:0]                rd_addr,
  input  logic [(1<<AW)-1:0][DW-1:0]   regs,
  input  logic                         byp_en,
  input  logic [AW-1:0]                byp_addr,
  input  logic [DW-1:0]                byp_data,
  output logic [DW-1:0]                rd_data
);
  always_comb begin
    rd_data = regs[rd_addr];
    if (rd_addr == '0)                          rd_data = '0;
    else if (byp_en && (rd_addr == byp_addr))   rd_data = byp_data;
  end
endmodule

module wb_grf #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_pc,
  input  logic [4:0]  wb_regaddr,
  input  logic [31:0] wb_alures,
  input  logic [31:0] wb_memres,
  input  logic        wb_memToReg,
  input  logic        wb_regWrite,
  input  logic        wb_jump,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] wb_data,
  output logic [31:0] commit_count,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [4:0]  trace_addr,
  output logic [31:0] trace_data
);
  localparam int NUM_RD = 2;
  localparam int AW     = 5;
  localparam int DW     = 32;

  typedef struct packed {
    logic          vld;
    logic [31:0]   pc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } trace_t;

  logic [(1<<AW)-1:0][DW-1:0] regs;
  logic [31:0]                cnt_q;
  trace_t                     trc_q;
  logic                       commit;
  logic [NUM_RD-1:0][AW-1:0]  rd_addr;
  logic [NUM_RD-1:0][DW-1:0]  rd_data;

  always_comb begin
    wb_data = wb_alures;
    if (wb_jump)          wb_data = wb_pc + 32'd8;
    else if (wb_memToReg) wb_data = wb_memres;
  end

  assign commit = wb_regWrite && (wb_regaddr != '0);

  // Entry 0 is never written, so it stays zero from reset onward.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs  <= '0;
      cnt_q <= '0;
      trc_q <= '{vld: 1'b0, pc: RESET_PC, addr: '0, data: '0};
    end else if (commit) begin
      regs[wb_regaddr] <= wb_data;
      cnt_q            <= cnt_q + 32'd1;
      trc_q            <= '{vld: 1'b1, pc: wb_pc, addr: wb_regaddr, data: wb_data};
    end else begin
      trc_q.vld <= 1'b0;
    end
  end

  assign rd_addr = {rt_addr, rs_addr};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    wb_grf_rdport #(.AW(AW), .DW(DW)) u_rd (
      .rd_addr  (rd_addr[p]),
      .regs     (regs),
      .byp_en   (commit),
      .byp_addr (wb_regaddr),
      .byp_data (wb_data),
      .rd_data  (rd_data[p])
    );
  end

  assign rs_data      = rd_data[0];
  assign rt_data      = rd_data[1];
  assign commit_count = cnt_q;
  assign trace_valid  = trc_q.vld;
  assign trace_pc     = trc_q.pc;
  assign trace_addr   = trc_q.addr;
  assign trace_data   = trc_q.data;
endmodule

// File: tb/tb_wb_grf.sv
// Directed bench for wb_grf: reset, write select priority, bypass, $0 protection,
// back-to-back trace pulses, counter wrap and mid-cycle reset.

module tb_wb_grf;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] wb_pc = '0;
  logic [4:0]  wb_regaddr = '0;
  logic [31:0] wb_alures = '0;
  logic [31:0] wb_memres = '0;
  logic        wb_memToReg = 1'b0;
  logic        wb_regWrite = 1'b0;
  logic        wb_jump = 1'b0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic [31:0] rs_data, rt_data, wb_data, commit_count;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [4:0]  trace_addr;
  logic [31:0] trace_data;

  int tests = 0;
  int fails = 0;

  wb_grf #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset),
    .wb_pc(wb_pc), .wb_regaddr(wb_regaddr), .wb_alures(wb_alures), .wb_memres(wb_memres),
    .wb_memToReg(wb_memToReg), .wb_regWrite(wb_regWrite), .wb_jump(wb_jump),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .wb_data(wb_data), .commit_count(commit_count),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_addr(trace_addr), .trace_data(trace_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    wb_regWrite = 1'b1; wb_regaddr = a; wb_alures = v;
    wb_memToReg = 1'b0; wb_jump = 1'b0;
  endtask

  initial begin
    // reset asserted between edges
    #1 reset = 1'b0;
    rs_addr = 5'd5;
    #2;
    check("rst_cnt",   commit_count, 32'd0);
    check("rst_tv",    {31'd0, trace_valid}, 32'd0);
    check("rst_tpc",   trace_pc, 32'h0000_3000);
    check("rst_taddr", {27'd0, trace_addr}, 32'd0);
    check("rst_tdata", trace_data, 32'd0);
    check("rst_rs5",   rs_data, 32'd0);
    @(negedge clk); reset = 1'b1;

    // ALU write with bypass
    @(negedge clk);
    wb_pc = 32'h0000_3004; wr(5'd8, 32'h1234_5678); rs_addr = 5'd8;
    #1;
    check("alu_byp_rs", rs_data, 32'h1234_5678);
    check("alu_wbdata", wb_data, 32'h1234_5678);
    @(posedge clk); #1;
    check("alu_tv",    {31'd0, trace_valid}, 32'd1);
    check("alu_taddr", {27'd0, trace_addr}, 32'd8);
    check("alu_tdata", trace_data, 32'h1234_5678);
    check("alu_tpc",   trace_pc, 32'h0000_3004);
    check("alu_cnt",   commit_count, 32'd1);
    wb_regWrite = 1'b0;
    @(negedge clk);
    check("alu_stored", rs_data, 32'h1234_5678);
    @(posedge clk); #1;
    check("alu_tv_off", {31'd0, trace_valid}, 32'd0);
    check("alu_tpc_hold", trace_pc, 32'h0000_3004);
    check("alu_cnt_hold", commit_count, 32'd1);

    // jump beats load
    @(negedge clk);
    wb_regWrite = 1'b1; wb_regaddr = 5'd31; wb_pc = 32'h0000_3010;
    wb_memToReg = 1'b1; wb_jump = 1'b1; wb_memres = 32'hDEAD_BEEF; wb_alures = 32'h5555_5555;
    rt_addr = 5'd31;
    #1;
    check("jmp_wbdata", wb_data, 32'h0000_3018);
    check("jmp_byp_rt", rt_data, 32'h0000_3018);
    @(posedge clk); #1;
    wb_regWrite = 1'b0;
    #1;
    check("jmp_stored", rt_data, 32'h0000_3018);
    check("jmp_cnt", commit_count, 32'd2);
    @(negedge clk);
    wb_regWrite = 1'b1; wb_jump = 1'b0;
    #1;
    check("ld_wbdata", wb_data, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    wb_regWrite = 1'b0;
    #1;
    check("ld_stored", rt_data, 32'hDEAD_BEEF);
    check("ld_tdata", trace_data, 32'hDEAD_BEEF);

    // $0 is never written
    @(negedge clk);
    wr(5'd0, 32'hFFFF_FFFF); rs_addr = 5'd0; rt_addr = 5'd0;
    #1;
    check("z_rs", rs_data, 32'd0);
    check("z_rt", rt_data, 32'd0);
    @(posedge clk); #1;
    check("z_cnt", commit_count, 32'd3);
    check("z_tv", {31'd0, trace_valid}, 32'd0);
    check("z_rs_after", rs_data, 32'd0);

    // back-to-back commits and dual read
    @(negedge clk); wr(5'd1, 32'd1);
    @(posedge clk); #1;
    check("b2b_tv1", {31'd0, trace_valid}, 32'd1);
    @(negedge clk); wr(5'd2, 32'd2);
    @(posedge clk); #1;
    check("b2b_tv2", {31'd0, trace_valid}, 32'd1);
    @(negedge clk); wr(5'd1, 32'd3); rs_addr = 5'd1; rt_addr = 5'd1;
    #1;
    check("b2b_byp_rs", rs_data, 32'd3);
    check("b2b_byp_rt", rt_data, 32'd3);
    @(posedge clk); #1;
    check("b2b_tv3", {31'd0, trace_valid}, 32'd1);
    check("b2b_taddr", {27'd0, trace_addr}, 32'd1);
    check("b2b_cnt", commit_count, 32'd6);
    wb_regWrite = 1'b0;
    @(negedge clk);
    check("dual_rs", rs_data, 32'd3);
    check("dual_rt", rt_data, 32'd3);
    rt_addr = 5'd2;
    #1;
    check("rd_r2", rt_data, 32'd2);

    // counter wrap
    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.cnt_q;
    #1;
    check("wrap_pre", commit_count, 32'hFFFF_FFFF);
    wr(5'd3, 32'h0000_0033);
    @(posedge clk); #1;
    check("wrap_cnt", commit_count, 32'd0);
    check("wrap_tv", {31'd0, trace_valid}, 32'd1);

    // reset mid-cycle with a pending commit
    @(negedge clk);
    wr(5'd4, 32'h0000_AAAA); rs_addr = 5'd8; rt_addr = 5'd4;
    #2 reset = 1'b0;
    #1;
    check("mrst_cnt", commit_count, 32'd0);
    check("mrst_tv",  {31'd0, trace_valid}, 32'd0);
    check("mrst_tpc", trace_pc, 32'h0000_3000);
    check("mrst_rs8", rs_data, 32'd0);
    @(posedge clk); #1;
    check("mrst_hold_cnt", commit_count, 32'd0);
    @(negedge clk);
    wb_regWrite = 1'b0; reset = 1'b1;
    #1;
    check("mrst_r4_lost", rt_data, 32'd0);
    check("mrst_r8", rs_data, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
